// File: rtl/ripple_cla16.sv
// ripple_cla16: multi-cycle 16-bit adder, four 4-bit CLA stages chained by a registered ripple carry
module ripple_cla16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        c_in,
  output logic [15:0] Output,
  output logic        c_out,
  output logic        ready
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, next;
  logic [1:0]  stage;
  logic [15:0] a_r, b_r, sum_r;
  logic        carry;
  logic [3:0]  a_n, b_n, g, p, s;
  logic [4:0]  c;
  // 4-bit carry-lookahead on the nibble selected by the stage counter
  always_comb begin
    a_n = a_r[{stage, 2'b00} +: 4];
    b_n = b_r[{stage, 2'b00} +: 4];
    g = a_n & b_n;
    p = a_n ^ b_n;
    c[0] = carry;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s = p ^ c[3:0];
  end
  // next state: en low aborts CALC and releases DONE; last stage completes
  always_comb begin
    next = state;
    next = (state == IDLE) ? (en ? CALC : IDLE)
         : (state == CALC) ? (!en ? IDLE : (&stage ? DONE : CALC))
         : (en ? DONE : IDLE);
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= next;
  end
  // datapath: capture operands, accumulate one nibble per edge, publish only on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      sum_r <= '0;
      carry <= 1'b0;
      stage <= '0;
      Output <= '0;
      c_out <= 1'b0;
      ready <= 1'b0;
    end else begin
      case (state)
        IDLE: if (en) begin
          a_r <= A;
          b_r <= B;
          carry <= c_in;
          stage <= '0;
          ready <= 1'b0;
        end
        CALC: if (en) begin
          sum_r[{stage, 2'b00} +: 4] <= s;
          carry <= c[4];
          stage <= stage + 2'd1;
          if (&stage) begin
            Output <= {s, sum_r[11:0]};
            c_out <= c[4];
            ready <= 1'b1;
          end
        end
        DONE: if (!en) ready <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ripple_cla16.sv
// tb_ripple_cla16: vector table, random ops vs arithmetic model, abort and reset sequences
module tb_ripple_cla16;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic        c_in = 1'b0;
  logic [15:0] Output;
  logic        c_out, ready;
  int checks = 0, errors = 0;

  ripple_cla16 dut (.clk(clk), .rst_n(rst_n), .en(en), .A(A), .B(B), .c_in(c_in),
                    .Output(Output), .c_out(c_out), .ready(ready));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [16:0] exp;
    int          hold;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b, input logic ci);
    return {1'b0, a} + {1'b0, b} + {16'b0, ci};
  endfunction

  // full operation: capture, scramble inputs after capture, check latency, hold, release
  task automatic do_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic [16:0] exp, input int hold);
    @(negedge clk);
    en = 1'b1; A = a; B = b; c_in = ci;
    @(negedge clk);
    A = ~a; B = $urandom; c_in = ~ci;
    repeat (3) @(negedge clk);
    check({nm, " ready before E4"}, {31'b0, ready}, 32'd0);
    @(negedge clk);
    check({nm, " ready at E4"}, {31'b0, ready}, 32'd1);
    check({nm, " sum"}, {15'b0, c_out, Output}, {15'b0, exp});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({nm, " hold"}, {15'b0, ready, c_out, Output}, {15'b0, 1'b1, exp});
    end
    en = 1'b0;
    @(negedge clk);
    check({nm, " release ready"}, {31'b0, ready}, 32'd0);
    check({nm, " release keeps"}, {15'b0, c_out, Output}, {15'b0, exp});
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] prev;
    vecs[0] = '{16'd127, 16'd127, 1'b0, 17'd254, 4};
    vecs[1] = '{16'h000F, 16'h0001, 1'b0, 17'h00010, 0};
    vecs[2] = '{16'h0FFF, 16'h0001, 1'b0, 17'h01000, 0};
    vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 17'h10000, 0};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, 1};
    vecs[5] = '{16'h1234, 16'h8765, 1'b1, 17'h0999A, 0};
    #3;
    check("reset values", {14'b0, ready, c_out, Output}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].exp, vecs[i].hold);
    for (int i = 0; i < 20; i++) begin
      ra = $urandom; rb = $urandom; rc = $urandom_range(0, 1);
      do_op($sformatf("rand%0d", i), ra, rb, rc, model(ra, rb, rc), 0);
    end
    // abort after two CALC edges: previous result must survive, ready never rises
    prev = {c_out, Output};
    @(negedge clk);
    en = 1'b1; A = 16'hAAAA; B = 16'h5555; c_in = 1'b1;
    repeat (3) @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort", {14'b0, ready, c_out, Output}, {14'b0, 1'b0, prev});
    end
    do_op("after abort", 16'hAAAA, 16'h5555, 1'b1, model(16'hAAAA, 16'h5555, 1'b1), 0);
    // reset mid-CALC, asynchronously
    @(negedge clk);
    en = 1'b1; A = 16'h7777; B = 16'h1111; c_in = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset mid-calc", {14'b0, ready, c_out, Output}, 32'd0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op("after reset1", 16'h7777, 16'h1111, 1'b0, model(16'h7777, 16'h1111, 1'b0), 0);
    // reset while in DONE
    @(negedge clk);
    en = 1'b1; A = 16'hF00F; B = 16'h0FF1; c_in = 1'b1;
    repeat (5) @(negedge clk);
    check("done before reset", {14'b0, ready, c_out, Output}, {14'b0, 1'b1, model(16'hF00F, 16'h0FF1, 1'b1)});
    #2 rst_n = 1'b0;
    #1 check("reset in done", {14'b0, ready, c_out, Output}, 32'd0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op("after reset2", 16'hC3C3, 16'h3C3D, 1'b0, model(16'hC3C3, 16'h3C3D, 1'b0), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ripple_cla16.md
Name: ripple_cla16

Overview:
- Multi-cycle 16-bit adder computing A + B + c_in.
- Built as four 4-bit carry-lookahead (CLA) stages chained by a ripple carry; one stage is evaluated per clock.
- Used as the datapath adder of the 8-bit FPGA computer where a short multi-cycle latency is acceptable.
- Controlled by a level-sensitive enable; a `ready` flag marks a valid result.

Parameters:
- None. Width is fixed at 16 bits, with four 4-bit stages.

Ports:
- clk  input  1  rising-edge system clock
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  start/hold request, level-sensitive
- A  input  16  addend
- B  input  16  addend
- c_in  input  1  carry into bit 0
- Output  output  16  registered sum, (A+B+c_in)[15:0]
- c_out  output  1  registered carry out of bit 15
- ready  output  1  high when Output and c_out hold a completed result

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low. All state changes on the rising clk edge, except reset.
- Reset (rst_n=0, immediate, regardless of clk):
  - state=IDLE, stage counter=0, internal carry=0, internal sum=0.
  - Output=16'h0000, c_out=0, ready=0.
- States: IDLE, CALC, DONE.
- IDLE, edge with en=1:
  - Latch A, B into operand registers; load internal carry with c_in.
  - Set stage=0, ready=0, go to CALC.
  - A, B, c_in changes after this capture edge are ignored until the next capture.
- IDLE, edge with en=0: remain in IDLE; outputs hold.
- CALC, one nibble per edge. For stage k (0..3), on nibble bits [4k+3:4k]:
  - g=a&b, p=a^b.
  - Carries by lookahead equations:
    - c1=g0|p0c
    - c2=g1|p1g0|p1p0c
    - c3=g2|p2g1|p2p1g0|p2p1p0c
    - c4=g3|p3g2|p3p2g1|p3p2p1g0|p3p2p1p0c
  - Sum bits s_i=p_i^c_i.
  - Write the nibble into the internal sum; internal carry <= c4; stage <= k+1.
- Completion, on the edge that processes stage 3:
  - Output <= full internal sum, including nibble 3; c_out <= c4 of stage 3.
  - ready <= 1; go to DONE.
- Latency: capture on edge E0; stages on E1–E4; ready, Output and c_out valid after E4 (4 cycles after capture).
- Output and c_out update only at completion. They are never partially updated and otherwise hold their last completed result.
- CALC with en=0 on any edge (abort): go to IDLE, ready stays 0, Output/c_out unchanged, partial result discarded.
- DONE with en=1: hold. ready=1; Output/c_out stable.
- DONE with en=0: on that edge, ready <= 0 and go to IDLE; Output/c_out retain the result. A new operation needs en low for at least one edge, then high again.
- Arithmetic: unsigned, modulo 2^16; {c_out,Output} = A+B+c_in as a 17-bit value. Wrap-around is reported only via c_out; there is no overflow flag.
- Reset asserted mid-operation aborts immediately to the reset values above.

Test Plan:
- A=127, B=127, c_in=0, en=1 held 7+ cycles -> ready rises exactly 4 cycles after the capture edge; Output=16'd254, c_out=0. en dropped -> ready=0 next edge, Output stays 254.
- A=16'h000F, B=16'h0001, c_in=0 -> Output=16'h0010, c_out=0 (carry crosses nibble boundary). A=16'h0FFF, B=16'h0001 -> 16'h1000, c_out=0.
- A=16'hFFFF, B=16'h0001, c_in=0 -> Output=16'h0000, c_out=1. A=16'hFFFF, B=16'hFFFF, c_in=1 -> Output=16'hFFFF, c_out=1.
- Operand stability: change A/B on the cycle after capture -> result reflects the captured values only.
- Abort: en deasserted after 2 CALC edges -> ready never rises, Output keeps the previous result. Re-assert en -> a fresh 4-cycle operation completes correctly.
- Reset: pull rst_n low mid-CALC and while in DONE -> Output=0, c_out=0, ready=0 immediately without a clock edge. After release, a new operation works normally.
